wbc_arbiter: RTL

WBC_ARBITER -- requirements
Module: wbc_arbiter

---
 rtl/wbc_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wbc_arbiter.sv
// Round-robin arbiter sharing one classic-Wishbone slave among NM masters.
// Optional slave watchdog enabled by defining WBC_ARB_TIMEOUT_EN.
module wbc_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NM-1:0]        i_mcyc,
    input  logic [NM-1:0]        i_mstb,
    input  logic [NM-1:0]        i_mwe,
    input  logic [NM*AW-1:0]     i_maddr,
    input  logic [NM*DW-1:0]     i_mdata,
    input  logic [NM*DW/8-1:0]   i_msel,
    output logic [NM-1:0]        o_mack,
    output logic [NM-1:0]        o_merr,
    output logic [DW-1:0]        o_mdata,
    output logic [NM-1:0]        o_grant,
    output logic                 o_scyc,
    output logic                 o_sstb,
    output logic                 o_swe,
    output logic [AW-1:0]        o_saddr,
    output logic [DW-1:0]        o_sdata,
    output logic [DW/8-1:0]      o_ssel,
    input  logic                 i_sack,
    input  logic                 i_serr,
    input  logic [DW-1:0]        i_sdata
);

    localparam int          SW  = DW / 8;
    localparam int          IW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned NMU = NM;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_owner;
    logic          rst_sync;

    logic [NM-1:0] req;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [NM-1:0] win_onehot;
    logic          own_cyc;
    logic          own_stb;
    logic          wd_hit;

    // Assert asynchronously, release on the first edge so a grant can land on the second.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync <= 1'b0;
        end else begin
            rst_sync <= 1'b1;
        end
    end

    assign req = i_mcyc & i_mstb;

    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int unsigned k = 1; k <= NMU; k++) begin
            logic [IW-1:0] cand;
            cand = IW'((32'(last_owner) + k) % NMU);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        for (int unsigned m = 0; m < NMU; m++) begin
            if (win_found && win_idx == IW'(m)) begin
                win_onehot[m] = 1'b1;
            end
        end
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        for (int unsigned m = 0; m < NMU; m++) begin
            if (owner == IW'(m)) begin
                own_cyc = i_mcyc[m];
                own_stb = i_mstb[m];
            end
        end
    end

`ifdef WBC_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_hit = (state == OWNED) && (wd_cnt == 16'(TIMEOUT));

    always_ff @(posedge i_clk or negedge rst_sync) begin
        if (!rst_sync) begin
            wd_cnt <= '0;
        end else if (state == OWNED && own_stb && !i_sack && !i_serr && !wd_hit) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NM - 1);
            o_grant    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state      <= OWNED;
                        owner      <= win_idx;
                        last_owner <= win_idx;
                        o_grant    <= win_onehot;
                    end
                end
                OWNED: begin
                    if (!own_cyc || wd_hit) begin
                        state   <= IDLE;
                        o_grant <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_scyc  = 1'b0;
        o_sstb  = 1'b0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        o_mack  = '0;
        o_merr  = '0;
        o_mdata = i_sdata;
        if (state == OWNED) begin
            // A watchdog expiry withdraws the strobe and reports ERR in the same cycle.
            o_scyc = own_cyc & ~wd_hit;
            o_sstb = own_stb & ~wd_hit;
            for (int unsigned m = 0; m < NMU; m++) begin
                if (owner == IW'(m)) begin
                    o_swe     = i_mwe[m];
                    o_saddr   = i_maddr[m*AW +: AW];
                    o_sdata   = i_mdata[m*DW +: DW];
                    o_ssel    = i_msel[m*SW +: SW];
                    o_mack[m] = i_sack & ~wd_hit;
                    o_merr[m] = i_serr | wd_hit;
                end
            end
        end
    end

endmodule
